// File: rtl/fifo_bus_write.sv
// rtl/fifo_bus_write.sv - write-side bus FIFO draining local words onto the memory bus in bursts
// Optional sticky overflow flag: define BUS_WR_OVERFLOW_CHECK_EN.
module fifo_bus_write #(
   parameter int DATA_LEN            = 16,
   parameter int DEPTH               = 32,
   parameter int ADDR_LEN            = $clog2(DEPTH),
   parameter int BURST_LEN           = 4,
   parameter int NUM_PIPELINE_STAGES = 0
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [DATA_LEN-1:0] wr_data,
   input  logic                wr_en,
   input  logic                flush,
   output logic                full,
   output logic                empty,
   output logic                bus_req,
   input  logic                bus_grant,
   output logic                bus_valid,
   output logic [DATA_LEN-1:0] bus_data,
   output logic                bus_last,
   input  logic                bus_ready,
   output logic                overflow
);

   localparam logic [ADDR_LEN:0] DEPTH_C = (ADDR_LEN+1)'(DEPTH);
   localparam logic [ADDR_LEN:0] FULL_C  = (ADDR_LEN+1)'(DEPTH - NUM_PIPELINE_STAGES);
   localparam logic [ADDR_LEN:0] BURST_C = (ADDR_LEN+1)'(BURST_LEN);
   localparam logic [ADDR_LEN:0] ONE_C   = (ADDR_LEN+1)'(1);
   localparam logic [ADDR_LEN:0] TWO_C   = (ADDR_LEN+1)'(2);

   typedef enum logic [1:0] {IDLE, REQ, SEND} state_t;

   state_t              state;
   logic [DATA_LEN-1:0] mem [DEPTH];
   logic [ADDR_LEN-1:0] wr_ptr;
   logic [ADDR_LEN-1:0] rd_ptr;
   logic [ADDR_LEN:0]   count;
   logic [ADDR_LEN:0]   count_next;
   logic [ADDR_LEN:0]   remaining;
   logic [ADDR_LEN:0]   grant_len;
   logic                push;
   logic                pop;

   // count covers the word sitting in bus_data until it is accepted, so its slot stays reserved
   assign push      = wr_en && (count < DEPTH_C);
   assign pop       = bus_valid && bus_ready;
   assign empty     = (count == '0);
   assign grant_len = (count < BURST_C) ? count : BURST_C;

   always_comb begin
      count_next = count;
      if (push && !pop)
         count_next = count + ONE_C;
      else if (!push && pop)
         count_next = count - ONE_C;
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         remaining <= '0;
         full      <= 1'b0;
         bus_req   <= 1'b0;
         bus_valid <= 1'b0;
         bus_last  <= 1'b0;
         bus_data  <= '0;
      end else begin
         count <= count_next;
         full  <= (count_next >= FULL_C);
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         case (state)
            IDLE: begin
               bus_req <= 1'b0;
               if ((count >= BURST_C) || (flush && (count != '0))) begin
                  state   <= REQ;
                  bus_req <= 1'b1;
               end
            end
            REQ: begin
               bus_req <= 1'b1;
               if (bus_grant) begin
                  remaining <= grant_len;
                  bus_data  <= mem[rd_ptr];
                  rd_ptr    <= rd_ptr + 1'b1;
                  bus_valid <= 1'b1;
                  bus_last  <= (grant_len == ONE_C);
                  state     <= SEND;
               end
            end
            SEND: begin
               if (pop) begin
                  if (remaining == ONE_C) begin
                     bus_valid <= 1'b0;
                     bus_last  <= 1'b0;
                     bus_req   <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     remaining <= remaining - ONE_C;
                     bus_data  <= mem[rd_ptr];
                     rd_ptr    <= rd_ptr + 1'b1;
                     bus_last  <= (remaining == TWO_C);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef BUS_WR_OVERFLOW_CHECK_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         overflow <= 1'b0;
      else if (wr_en && (count == DEPTH_C))
         overflow <= 1'b1;
   end
`else
   assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_bus_write.sv
// tb/tb_fifo_bus_write.sv - directed self-checking bench for fifo_bus_write
module tb_fifo_bus_write;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [15:0] wr_data = '0;
   logic        wr_en = 1'b0;
   logic        flush = 1'b0;
   logic        full;
   logic        empty;
   logic        bus_req;
   logic        bus_grant = 1'b0;
   logic        bus_valid;
   logic [15:0] bus_data;
   logic        bus_last;
   logic        bus_ready = 1'b0;
   logic        overflow;

   int checks = 0;
   int errors = 0;
   logic [15:0] q[$];

   fifo_bus_write dut (
      .clk(clk), .rstn(rstn), .wr_data(wr_data), .wr_en(wr_en), .flush(flush),
      .full(full), .empty(empty), .bus_req(bus_req), .bus_grant(bus_grant),
      .bus_valid(bus_valid), .bus_data(bus_data), .bus_last(bus_last),
      .bus_ready(bus_ready), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [15:0] d);
      wr_en = 1'b1;
      wr_data = d;
      cyc();
      wr_en = 1'b0;
      q.push_back(d);
   endtask

   task automatic drain_burst(input int n, input bit push_along, input logic [15:0] push_base);
      logic [15:0] exp;
      int t = 0;
      while (!bus_req && t < 20) begin
         cyc();
         t++;
      end
      checks++;
      if (bus_req !== 1'b1) begin
         errors++;
         $display("FAIL burst_req_timeout got bus_req=%b want 1", bus_req);
         return;
      end
      bus_ready = 1'b1;
      bus_grant = 1'b1;
      cyc();
      bus_grant = 1'b0;
      for (int i = 0; i < n; i++) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL burst_word%0d no expected word left, got data=%h", i, bus_data);
         end else begin
            exp = q.pop_front();
            if (bus_valid !== 1'b1 || bus_data !== exp || bus_last !== (i == n - 1)) begin
               errors++;
               $display("FAIL burst_word%0d got valid=%b data=%h last=%b want valid=1 data=%h last=%b",
                        i, bus_valid, bus_data, bus_last, exp, (i == n - 1));
            end
         end
         if (push_along) begin
            wr_en = 1'b1;
            wr_data = push_base + 16'(i);
            q.push_back(push_base + 16'(i));
         end
         cyc();
         wr_en = 1'b0;
      end
      checks++;
      if (bus_valid !== 1'b0 || bus_req !== 1'b0 || bus_last !== 1'b0) begin
         errors++;
         $display("FAIL burst_end got valid=%b req=%b last=%b want 0 0 0", bus_valid, bus_req, bus_last);
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      cyc();
      checks++;
      if (full !== 1'b0 || bus_req !== 1'b0 || bus_valid !== 1'b0 || bus_last !== 1'b0 ||
          bus_data !== 16'h0 || overflow !== 1'b0 || empty !== 1'b1) begin
         errors++;
         $display("FAIL reset_state got full=%b req=%b valid=%b last=%b data=%h ovf=%b empty=%b want 0 0 0 0 0000 0 1",
                  full, bus_req, bus_valid, bus_last, bus_data, overflow, empty);
      end
      rstn = 1'b1;
      cyc();
   endtask

   task automatic test_full_burst();
      for (int i = 1; i <= 4; i++) push_word(16'(i));
      checks++;
      if (bus_req !== 1'b0) begin
         errors++;
         $display("FAIL req_early got %b want 0", bus_req);
      end
      cyc();
      checks++;
      if (bus_req !== 1'b1) begin
         errors++;
         $display("FAIL req_after_push got %b want 1", bus_req);
      end
      drain_burst(4, 1'b0, 16'h0);
      checks++;
      if (empty !== 1'b1) begin
         errors++;
         $display("FAIL empty_after_burst got %b want 1", empty);
      end
   endtask

   task automatic test_flush();
      push_word(16'hAAAA);
      push_word(16'hBBBB);
      for (int i = 0; i < 3; i++) begin
         cyc();
         checks++;
         if (bus_req !== 1'b0) begin
            errors++;
            $display("FAIL no_req_without_flush cycle %0d got %b want 0", i, bus_req);
         end
      end
      flush = 1'b1;
      drain_burst(2, 1'b0, 16'h0);
      flush = 1'b0;
   endtask

   task automatic test_stall();
      bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [15:0] w [4] = '{16'h0301, 16'h0302, 16'h0303, 16'h0304};
      int idx = 0;
      for (int i = 0; i < 4; i++) push_word(w[i]);
      for (int i = 0; i < 4; i++) void'(q.pop_back());
      cyc();
      bus_ready = 1'b0;
      bus_grant = 1'b1;
      cyc();
      bus_grant = 1'b0;
      for (int c = 0; c < 7; c++) begin
         bus_ready = pat[c];
         checks++;
         if (bus_valid !== 1'b1 || bus_data !== w[idx] || bus_last !== (idx == 3)) begin
            errors++;
            $display("FAIL stall_cycle%0d got valid=%b data=%h last=%b want valid=1 data=%h last=%b",
                     c, bus_valid, bus_data, bus_last, w[idx], (idx == 3));
         end
         if (pat[c]) idx++;
         cyc();
      end
      bus_ready = 1'b0;
      checks++;
      if (bus_valid !== 1'b0 || bus_req !== 1'b0 || empty !== 1'b1) begin
         errors++;
         $display("FAIL stall_end got valid=%b req=%b empty=%b want 0 0 1", bus_valid, bus_req, empty);
      end
   endtask

   task automatic test_fill_overflow();
      logic exp_ovf;
`ifdef BUS_WR_OVERFLOW_CHECK_EN
      exp_ovf = 1'b1;
`else
      exp_ovf = 1'b0;
`endif
      bus_ready = 1'b0;
      for (int i = 0; i < 31; i++) push_word(16'h4000 + 16'(i));
      checks++;
      if (full !== 1'b0) begin
         errors++;
         $display("FAIL full_at_31 got %b want 0", full);
      end
      push_word(16'h401F);
      checks++;
      if (full !== 1'b1 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL full_at_32 got full=%b ovf=%b want 1 0", full, overflow);
      end
      wr_en = 1'b1;
      wr_data = 16'hDEAD;
      cyc();
      wr_en = 1'b0;
      checks++;
      if (overflow !== exp_ovf || full !== 1'b1) begin
         errors++;
         $display("FAIL overflow_write got ovf=%b full=%b want %b 1", overflow, full, exp_ovf);
      end
      for (int b = 0; b < 8; b++) drain_burst(4, 1'b0, 16'h0);
      checks++;
      if (empty !== 1'b1 || full !== 1'b0 || overflow !== exp_ovf) begin
         errors++;
         $display("FAIL drain_all got empty=%b full=%b ovf=%b want 1 0 %b", empty, full, overflow, exp_ovf);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) push_word(16'h5000 + 16'(i));
      drain_burst(4, 1'b1, 16'h5100);
      drain_burst(4, 1'b1, 16'h5104);
      drain_burst(4, 1'b0, 16'h0);
      drain_burst(4, 1'b0, 16'h0);
      checks++;
      if (empty !== 1'b1) begin
         errors++;
         $display("FAIL b2b_empty got %b want 1", empty);
      end
   endtask

   task automatic test_reset_mid_burst();
      for (int i = 0; i < 4; i++) push_word(16'h6000 + 16'(i));
      cyc();
      bus_ready = 1'b1;
      bus_grant = 1'b1;
      cyc();
      bus_grant = 1'b0;
      cyc();
      cyc();
      rstn = 1'b0;
      #1;
      checks++;
      if (bus_valid !== 1'b0 || bus_req !== 1'b0 || bus_last !== 1'b0) begin
         errors++;
         $display("FAIL async_reset got valid=%b req=%b last=%b want 0 0 0", bus_valid, bus_req, bus_last);
      end
      cyc();
      rstn = 1'b1;
      q.delete();
      cyc();
      cyc();
      checks++;
      if (empty !== 1'b1 || bus_req !== 1'b0 || bus_valid !== 1'b0) begin
         errors++;
         $display("FAIL after_reset got empty=%b req=%b valid=%b want 1 0 0", empty, bus_req, bus_valid);
      end
      bus_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_full_burst();
      test_flush();
      test_stall();
      test_fill_overflow();
      test_back_to_back();
      test_reset_mid_burst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_bus_write.md
Name: fifo_bus_write

Overview:
Write-side bus FIFO for the bus arbiter. It buffers words produced by the compute/namespace side and drains them onto the shared memory bus in fixed-length bursts, using a request/grant then valid/ready handshake. It is the transmit counterpart of the bus read FIFO: data flows from local logic to the bus.

Parameters:
DATA_LEN, 16, word width in bits
DEPTH, `BUS_FIFO_DEPTH (32), storage entries; power of two, >= 2*BURST_LEN
ADDR_LEN, `C_LOG_2(DEPTH), pointer width
BURST_LEN, 4, words per full burst; power of two, >= 1, <= DEPTH
NUM_PIPELINE_STAGES, 0, extra free slots reserved before full asserts (producer pipeline slack)

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
wr_data  input  DATA_LEN  word from producer
wr_en  input  1  write strobe; word accepted when count < DEPTH
flush  input  1  level; permits a partial burst when count < BURST_LEN
full  output  1  registered almost-full to producer
empty  output  1  combinational, count == 0
bus_req  output  1  registered bus request to arbiter
bus_grant  input  1  arbiter grant; sampled only in REQ
bus_valid  output  1  registered, bus_data valid
bus_data  output  DATA_LEN  registered head word
bus_last  output  1  registered, marks final word of burst
bus_ready  input  1  bus accepts word when bus_valid && bus_ready
overflow  output  1  sticky overflow flag (see Optional Feature)

Behaviour:
- Reset (async, rstn low): wr/rd pointers, count, burst counter = 0; state = IDLE; full = 0, bus_req = 0, bus_valid = 0, bus_last = 0, bus_data = 0, overflow = 0; empty = 1. Reset mid-burst discards all contents and drops bus_req/bus_valid immediately.
- Storage: DEPTH x DATA_LEN array; count is ADDR_LEN+1 bits, range 0..DEPTH; the full DEPTH capacity is usable; pointers wrap modulo DEPTH.
- Push: on wr_en && count < DEPTH, write mem[wr_ptr] and increment wr_ptr. When count == DEPTH, the write is dropped and the pointer is unchanged.
- Pop: on bus_valid && bus_ready.
- Count: push and pop in the same cycle leave count unchanged.
- full: registered as (count_next >= DEPTH - NUM_PIPELINE_STAGES), updated every cycle.
- FSM IDLE: bus_req = 0. Go to REQ when count >= BURST_LEN, or when flush && count != 0.
- FSM REQ: bus_req = 1, held until grant. On bus_grant:
  - latch burst_len = min(count, BURST_LEN);
  - load bus_data = mem[rd_ptr] and advance rd_ptr;
  - bus_valid = 1 next cycle, bus_last = (burst_len == 1);
  - go to SEND.
- Latency: grant at cycle t gives the first bus_valid at t+1.
- FSM SEND: bus_req stays 1.
  - On each transfer, decrement the remaining count.
  - If it was not the last word, load the next word into bus_data in the same cycle, so back-to-back words need no bubble. bus_last = 1 exactly on the final word.
  - On the final transfer: bus_valid, bus_last, bus_req go to 0 the next cycle; state returns to IDLE.
  - With bus_ready low, bus_data, bus_valid and bus_last hold stable.
- Burst length is frozen at grant; writes during SEND never extend the current burst.
- bus_grant outside REQ is ignored.
- Minimum one IDLE cycle between bursts.
- A flush-triggered partial burst always terminates with bus_last; flush deasserted mid-burst does not truncate it.

Optional Feature:
Macro BUS_WR_OVERFLOW_CHECK_EN.
- Defined: overflow sets on any wr_en while count == DEPTH and stays set until reset. Under FPGA simulation it also prints a `log.vh` error message.
- Undefined: overflow is tied to 0 and there is no extra logic; the write is still dropped silently.

Test Plan:
1. Reset, write 4 words 0x0001..0x0004 → bus_req = 1 the cycle after the 4th push. Grant at t → bus_valid at t+1 with 0x0001; with bus_ready = 1 the words are 0x0001..0x0004 on consecutive cycles, bus_last on 0x0004. Then bus_req = 0 and empty = 1.
2. Write 2 words (0xAAAA, 0xBBBB), hold flush = 1 → one burst of 2 words, bus_last on 0xBBBB; with count < 4 and flush = 0 there is no bus_req.
3. Burst of 4 with bus_ready toggled 1,0,0,1,1,0,1 → bus_data stable during stalls; exactly 4 transfers in order; bus_last asserted only with the 4th.
4. Fill 32 words with no grant → full = 1 registered after count reaches 32 (NUM_PIPELINE_STAGES = 0). A 33rd write is dropped and overflow = 1 (macro defined) or 0 (undefined). Drain → 32 words in order, including pointer wrap.
5. Simultaneous wr_en and pop during SEND for 8 cycles → count constant; burst length stays 4; the next burst starts after one IDLE cycle with the correct ordering.
6. Assert rstn low mid-burst after the 2nd transfer → bus_valid, bus_req, bus_last = 0 immediately; after release empty = 1 and state is IDLE.
